// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with NZCV flags, operands sampled on aluStart, one-cycle aluDone.
// Define ALU_SEQ_MUL_EN to build the multi-cycle shift-add multiplier behind opcode 1101.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] aluAIn,
  input  logic [WIDTH-1:0] aluBIn,
  input  logic [3:0]       aluCtl,
  input  logic             aluStart,
  output logic [WIDTH-1:0] aluOut,
  output logic [3:0]       condFlag,
  output logic             aluBusy,
  output logic             aluDone
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_MOVA = 4'b0000;
  localparam logic [3:0] OP_MOVB = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOTA = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_ADC  = 4'b1000;
  localparam logic [3:0] OP_SBC  = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1010;
  localparam logic [3:0] OP_SHR  = 4'b1011;
  localparam logic [3:0] OP_SAR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;
  localparam logic [3:0] OP_CMP  = 4'b1110;

  logic             acceptS;
  logic             mulStartS;
  logic             mulLastS;
  logic             nextBusyS;
  logic [WIDTH-1:0] prodLoS;
  logic [WIDTH-1:0] prodHiS;

  logic [SW-1:0]    amtS;
  logic             addCinS;
  logic             subCinS;
  logic [WIDTH:0]   sumS;
  logic [WIDTH:0]   diffS;
  logic [WIDTH:0]   shlS;
  logic [WIDTH:0]   shrS;
  logic [WIDTH:0]   sarS;
  logic             addVS;
  logic             subVS;
  logic [WIDTH-1:0] resS;
  logic             carryS;
  logic             ovfS;
  logic             writeOutS;
  logic [3:0]       flagS;

  assign acceptS = aluStart && !aluBusy;
  assign amtS    = aluBIn[SW-1:0];

  // Carry-in for ADC/SBC comes from the previous operation's registered C flag.
  assign addCinS = (aluCtl == OP_ADC) && condFlag[1];
  assign subCinS = (aluCtl == OP_SBC) && condFlag[1];
  assign sumS    = {1'b0, aluAIn} + {1'b0, aluBIn} + {{WIDTH{1'b0}}, addCinS};
  assign diffS   = {1'b0, aluAIn} - {1'b0, aluBIn} - {{WIDTH{1'b0}}, subCinS};
  assign addVS   = (aluAIn[WIDTH-1] == aluBIn[WIDTH-1]) && (sumS[WIDTH-1] != aluAIn[WIDTH-1]);
  assign subVS   = (aluAIn[WIDTH-1] != aluBIn[WIDTH-1]) && (diffS[WIDTH-1] != aluAIn[WIDTH-1]);

  // Shifts carry one guard bit so the last bit shifted out lands in a fixed position.
  assign shlS = {1'b0, aluAIn} << amtS;
  assign shrS = {aluAIn, 1'b0} >> amtS;
  assign sarS = $signed({aluAIn, 1'b0}) >>> amtS;

  // Single-cycle result and flag selection by opcode.
  always_comb begin
    resS      = aluAIn;
    carryS    = 1'b0;
    ovfS      = 1'b0;
    writeOutS = 1'b1;
    case (aluCtl)
      OP_MOVA: resS = aluAIn;
      OP_MOVB: resS = aluBIn;
      OP_AND:  resS = aluAIn & aluBIn;
      OP_OR:   resS = aluAIn | aluBIn;
      OP_XOR:  resS = aluAIn ^ aluBIn;
      OP_NOTA: resS = ~aluAIn;
      OP_ADD, OP_ADC: begin
        resS   = sumS[WIDTH-1:0];
        carryS = sumS[WIDTH];
        ovfS   = addVS;
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        resS      = diffS[WIDTH-1:0];
        carryS    = diffS[WIDTH];
        ovfS      = subVS;
        writeOutS = (aluCtl != OP_CMP);
      end
      OP_SHL: begin
        resS   = shlS[WIDTH-1:0];
        carryS = shlS[WIDTH];
      end
      OP_SHR: begin
        resS   = shrS[WIDTH:1];
        carryS = shrS[0];
      end
      OP_SAR: begin
        resS   = sarS[WIDTH:1];
        carryS = sarS[0];
      end
      default: resS = aluAIn;
    endcase
    flagS = {resS[WIDTH-1], (resS == {WIDTH{1'b0}}), carryS, ovfS};
  end

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} stateT;

  stateT            stateR;
  stateT            nextStateS;
  logic [WIDTH-1:0] mcandR;
  logic [WIDTH-1:0] mplrR;
  logic [WIDTH-1:0] accR;
  logic [SW-1:0]    cntR;
  logic [WIDTH:0]   stepSumS;

  // {accR, mplrR} forms the double-width product; each step adds and shifts right once.
  assign mulStartS = acceptS && (aluCtl == OP_MUL);
  assign stepSumS  = {1'b0, accR} + (mplrR[0] ? {1'b0, mcandR} : {(WIDTH+1){1'b0}});
  assign prodHiS   = stepSumS[WIDTH:1];
  assign prodLoS   = {stepSumS[0], mplrR[WIDTH-1:1]};
  assign mulLastS  = (stateR == ST_MUL) && (cntR == SW'(WIDTH-1));
  assign nextBusyS = (nextStateS == ST_MUL);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) stateR <= ST_IDLE;
    else       stateR <= nextStateS;
  end

  // FSM next-state logic.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      ST_IDLE: begin
        if (mulStartS) nextStateS = ST_MUL;
        else           nextStateS = ST_IDLE;
      end
      ST_MUL: begin
        if (mulLastS) nextStateS = ST_IDLE;
        else          nextStateS = ST_MUL;
      end
      default: nextStateS = ST_IDLE;
    endcase
  end

  // Multiplier operand capture and shift-add iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcandR <= {WIDTH{1'b0}};
      mplrR  <= {WIDTH{1'b0}};
      accR   <= {WIDTH{1'b0}};
      cntR   <= {SW{1'b0}};
    end else if (mulStartS) begin
      mcandR <= aluAIn;
      mplrR  <= aluBIn;
      accR   <= {WIDTH{1'b0}};
      cntR   <= {SW{1'b0}};
    end else if (stateR == ST_MUL) begin
      accR   <= prodHiS;
      mplrR  <= prodLoS;
      cntR   <= cntR + SW'(1);
    end
  end
`else
  assign mulStartS = 1'b0;
  assign mulLastS  = 1'b0;
  assign nextBusyS = 1'b0;
  assign prodLoS   = {WIDTH{1'b0}};
  assign prodHiS   = {WIDTH{1'b0}};
`endif

  // Result, flag, busy and done registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      aluOut   <= {WIDTH{1'b0}};
      condFlag <= 4'b0000;
      aluBusy  <= 1'b0;
      aluDone  <= 1'b0;
    end else begin
      aluBusy <= nextBusyS;
      aluDone <= 1'b0;
      if (mulLastS) begin
        aluOut   <= prodLoS;
        condFlag <= {prodLoS[WIDTH-1], (prodLoS == {WIDTH{1'b0}}), (|prodHiS), 1'b0};
        aluDone  <= 1'b1;
      end else if (acceptS && !mulStartS) begin
        if (writeOutS) aluOut <= resS;
        condFlag <= flagS;
        aluDone  <= 1'b1;
      end
    end
  end

endmodule
